param_serializer: RTL and testbench

Parametrised parallel-to-serial converter for the UART transmit path. It accepts a DATA_WIDTH-bit word through a valid/ready handshake and shifts it out one bit per `ser_en` tick, LSB- or MSB-first, with an optional appended even or odd parity bit. It sits between the TX holding register and the UART frame mux, which adds the start and stop bits. `ser_done` is a single-cycle pulse that tells the TX controller the data (and parity) bits are complete.

---
 rtl/param_serializer.sv | 96 +++++++++
 tb/tb_param_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// Parallel-to-serial converter for the UART TX path: valid/ready load, one bit per
// ser_en tick, selectable bit order and optional even/odd parity bit after the data.
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ser_en,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  par, par_nxt;
  logic                  done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par      <= par_nxt;
      ser_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    done_nxt    = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b1;
    ser_out     = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          shreg_nxt   = in_data;
          par_nxt     = (^in_data) ^ (PARITY_ODD != 0);
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        ser_out = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
        if (ser_en) begin
          shreg_nxt = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg[DATA_WIDTH-1:1]};
          // Counter saturates on the last bit so it never wraps inside a frame.
          if (bit_cnt == LAST) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        ser_out = par;
        if (ser_en) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer: five parameter variants driven with
// directed and random frames, checked against a bit-list model of each frame.
module tb_param_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din [5];
  logic        vld [5];
  logic        en  [5];
  logic        rdy [5];
  logic        so  [5];
  logic        bsy [5];
  logic        dn  [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .ser_en(en[0]), .ser_out(so[0]), .busy(bsy[0]), .ser_done(dn[0]));
  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .ser_en(en[1]), .ser_out(so[1]), .busy(bsy[1]), .ser_done(dn[1]));
  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .ser_en(en[2]), .ser_out(so[2]), .busy(bsy[2]), .ser_done(dn[2]));
  param_serializer #(.DATA_WIDTH(2), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .rst(rst), .in_data(din[3][1:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .ser_en(en[3]), .ser_out(so[3]), .busy(bsy[3]), .ser_done(dn[3]));
  param_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u4 (
    .clk(clk), .rst(rst), .in_data(din[4]), .in_valid(vld[4]), .in_ready(rdy[4]),
    .ser_en(en[4]), .ser_out(so[4]), .busy(bsy[4]), .ser_done(dn[4]));

  function automatic int wd(int k);
    case (k)
      3:       return 2;
      4:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic bit msb(int k);  return (k == 1 || k == 2 || k == 4); endfunction
  function automatic bit pen(int k);  return (k == 1 || k == 2);           endfunction
  function automatic bit podd(int k); return (k == 2);                     endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word while idle; returns one cycle after the accept edge.
  task automatic accept(int k, logic [15:0] data, logic en0);
    chk("in_ready_idle", 16'(rdy[k]), 16'd1);
    din[k] = data;
    vld[k] = 1'b1;
    en[k]  = en0;
    @(negedge clk);
    chk("busy_after_accept", 16'(bsy[k]), 16'd1);
  endtask

  // Expected frame = data bits in wire order, then parity if enabled; each bit held p cycles.
  task automatic play(int k, logic [15:0] data, int p, bit noise, bit hold, int limit);
    bit q[$];
    int w = wd(k);
    bit par = podd(k);
    for (int i = 0; i < w; i++) begin
      q.push_back(msb(k) ? data[w-1-i] : data[i]);
      par ^= data[i];
    end
    if (pen(k)) q.push_back(par);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      for (int c = 0; c < p; c++) begin
        chk("ser_out", 16'(so[k]), 16'(q[i]));
        chk("busy", 16'(bsy[k]), 16'd1);
        chk("in_ready_busy", 16'(rdy[k]), 16'd0);
        chk("ser_done_early", 16'(dn[k]), 16'd0);
        en[k] = (c == p - 1);
        if (noise) begin
          vld[k] = 1'($urandom_range(0, 1));
          din[k] = 16'($urandom);
        end else if (!hold) begin
          vld[k] = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic done_check(int k, bit keep);
    chk("ser_done_pulse", 16'(dn[k]), 16'd1);
    chk("ser_out_done", 16'(so[k]), 16'd1);
    chk("busy_done", 16'(bsy[k]), 16'd0);
    chk("in_ready_done", 16'(rdy[k]), 16'd1);
    if (!keep) begin
      vld[k] = 1'b0;
      en[k]  = 1'b0;
      @(negedge clk);
      chk("ser_done_clear", 16'(dn[k]), 16'd0);
      chk("ser_out_idle", 16'(so[k]), 16'd1);
    end
  endtask

  task automatic frame(int k, logic [15:0] data, int p, bit noise);
    accept(k, data, p == 1);
    play(k, data, p, noise, 1'b0, 999);
    done_check(k, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    int p;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din[k] = '0;
      vld[k] = 1'b0;
      en[k]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst_ser_out", 16'(so[k]), 16'd1);
      chk("rst_busy", 16'(bsy[k]), 16'd0);
      chk("rst_in_ready", 16'(rdy[k]), 16'd1);
      chk("rst_ser_done", 16'(dn[k]), 16'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-frame after 3 bits, with valid and ser_en also high.
    accept(0, 16'h00C3, 1'b1);
    play(0, 16'h00C3, 1, 1'b0, 1'b0, 3);
    rst = 1'b1;
    vld[0] = 1'b1;
    din[0] = 16'h00AA;
    @(negedge clk);
    rst = 1'b0;
    vld[0] = 1'b0;
    en[0] = 1'b0;
    chk("abort_ser_out", 16'(so[0]), 16'd1);
    chk("abort_busy", 16'(bsy[0]), 16'd0);
    chk("abort_in_ready", 16'(rdy[0]), 16'd1);
    chk("abort_ser_done", 16'(dn[0]), 16'd0);
    @(negedge clk);
    chk("abort_no_done", 16'(dn[0]), 16'd0);
    frame(0, 16'h005A, 1, 1'b0);

    // LSB-first continuous, parity even/odd MSB-first, sparse ticks with noise.
    frame(0, 16'h00B4, 1, 1'b0);
    frame(1, 16'h00B4, 1, 1'b0);
    frame(2, 16'h00B4, 1, 1'b0);
    frame(0, 16'h00B4, 16, 1'b1);

    // Back-to-back: valid held through the final tick; second word waits for the done cycle.
    accept(0, 16'h00B4, 1'b1);
    din[0] = 16'h000F;
    play(0, 16'h00B4, 1, 1'b0, 1'b1, 999);
    done_check(0, 1'b1);
    accept(0, 16'h000F, 1'b1);
    play(0, 16'h000F, 1, 1'b0, 1'b0, 999);
    done_check(0, 1'b0);

    // Width sweep.
    frame(3, 16'h0002, 1, 1'b0);
    frame(4, 16'h8001, 1, 1'b0);

    // Random words, tick spacing and busy-time noise on every variant.
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 4; r++) begin
        d = 16'($urandom) & 16'((32'd1 << wd(k)) - 1);
        p = int'($urandom_range(1, 4));
        frame(k, d, p, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
